// File: rtl/tt_frame_feeder_if.sv
// Host, TT-core and result signal bundle for tt_frame_feeder.
// slave is the feeder side; master is the host/TT-core side.
interface tt_frame_feeder_if;
  logic       h_valid;
  logic       h_ready;
  logic       h_last;
  logic [3:0] h_src;
  logic [3:0] h_dst;
  logic       in_valid;
  logic [3:0] source;
  logic [3:0] destination;
  logic       out_valid;
  logic [3:0] cost;
  logic       res_valid;
  logic [3:0] res_cost;
  logic [1:0] res_status;

  modport slave (
    input  h_valid, h_last, h_src, h_dst, out_valid, cost,
    output h_ready, in_valid, source, destination, res_valid, res_cost, res_status
  );

  modport master (
    output h_valid, h_last, h_src, h_dst, out_valid, cost,
    input  h_ready, in_valid, source, destination, res_valid, res_cost, res_status
  );
endinterface

// File: rtl/tt_frame_feeder.sv
// Buffers one host frame, replays it to the TT core, then waits for the result
// (or a timeout) and reports cost/status back to the host.
module tt_frame_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_frame_feeder_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ovf;
  logic [TW-1:0] timer;
  logic          rdy;
  logic [3:0]    cost_q;
  logic [1:0]    status_q;
  logic [3:0]    frame_a [DEPTH];
  logic [3:0]    frame_b [DEPTH];

  logic accept;
  logic room;
  logic last_word;

  assign accept    = bus.h_valid & rdy;
  assign room      = (wptr < PW'(DEPTH));
  assign last_word = (rptr == wptr - PW'(1));

  // Ready is registered so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      wptr     <= '0;
      rptr     <= '0;
      ovf      <= 1'b0;
      timer    <= '0;
      rdy      <= 1'b0;
      cost_q   <= '0;
      status_q <= 2'b00;
    end else begin
      case (state)
        COLLECT: begin
          rdy <= 1'b1;
          if (accept) begin
            if (room) wptr <= wptr + PW'(1);
            else      ovf  <= 1'b1;
            if (bus.h_last) begin
              rdy <= 1'b0;
              if (ovf || !room) begin
                state    <= DONE;
                cost_q   <= '0;
                status_q <= 2'b01;
              end else begin
                state <= SEND;
              end
            end
          end
        end
        SEND: begin
          rptr <= rptr + PW'(1);
          if (last_word) begin
            state <= WAIT;
            timer <= '0;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          // A result arriving on the timeout cycle takes priority.
          if (bus.out_valid) begin
            state    <= DONE;
            cost_q   <= bus.cost;
            status_q <= 2'b00;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state    <= DONE;
            cost_q   <= '0;
            status_q <= 2'b10;
          end
        end
        default: begin
          state <= COLLECT;
          wptr  <= '0;
          rptr  <= '0;
          ovf   <= 1'b0;
          timer <= '0;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == COLLECT && accept && room) begin
      frame_a[wptr[AW-1:0]] <= bus.h_src;
      frame_b[wptr[AW-1:0]] <= bus.h_dst;
    end
  end

  always_comb begin
    bus.h_ready     = rdy;
    bus.in_valid    = (state == SEND);
    bus.source      = '0;
    bus.destination = '0;
    if (state == SEND) begin
      bus.source      = frame_a[rptr[AW-1:0]];
      bus.destination = frame_b[rptr[AW-1:0]];
    end
    bus.res_valid  = (state == DONE);
    bus.res_cost   = cost_q;
    bus.res_status = status_q;
  end

endmodule

// File: doc/tt_frame_feeder.md
TT_FRAME_FEEDER -- requirements
Module: tt_frame_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning frame buffer depth in words (header plus edges).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of WAIT cycles before abort.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port h_valid  input  1  host word valid.
REQ-006 SHALL have port h_ready  output  1  feeder accepts a host word.
REQ-007 SHALL have port h_last  input  1  marks the final word of a frame.
REQ-008 SHALL have port h_src  input  4  header: start station; edge: endpoint A.
REQ-009 SHALL have port h_dst  input  4  header: target station; edge: endpoint B.
REQ-010 SHALL have port in_valid  output  1  frame word valid toward the TT core.
REQ-011 SHALL have port source  output  4  frame word field A toward the TT core.
REQ-012 SHALL have port destination  output  4  frame word field B toward the TT core.
REQ-013 SHALL have port out_valid  input  1  TT core result strobe.
REQ-014 SHALL have port cost  input  4  TT core result value.
REQ-015 SHALL have port res_valid  output  1  one-cycle result pulse to the host.
REQ-016 SHALL have port res_cost  output  4  reported cost.
REQ-017 SHALL have port res_status  output  2  00 ok, 01 overflow, 10 timeout.

Function
REQ-018 SHALL implement FSM states COLLECT, SEND, WAIT, DONE; reset state COLLECT.
REQ-019 SHALL assert h_ready=1 only in COLLECT; a word is accepted when h_valid&h_ready.
REQ-020 In COLLECT, SHALL write each accepted word to buf[wptr] and increment wptr while wptr<DEPTH.
REQ-021 SHALL discard accepted words once wptr==DEPTH and set the sticky ovf flag; wptr does not wrap.
REQ-022 SHALL, on acceptance of a word with h_last=1, go to DONE if ovf is set (frame not sent), otherwise to SEND.
REQ-023 SHALL treat a frame as word 0 = header, words 1..n = edges; a header-only frame (h_last on word 0) is legal and sends 1 word.
REQ-024 In SEND, SHALL drive in_valid=1 with source/destination=buf[rptr] for exactly wptr contiguous cycles, starting the cycle after the h_last handshake.
REQ-025 SHALL drive in_valid=0 and source=destination=0 in every state other than SEND.
REQ-026 After the last word, SHALL enter WAIT with in_valid low on the following cycle and clear the timer to 0.
REQ-027 In WAIT, SHALL increment the timer each cycle; on out_valid=1, capture cost, set status 00 and go to DONE.
REQ-028 In WAIT, when the timer reaches TIMEOUT-1 without out_valid, SHALL set status 10, cost 0 and go to DONE.
REQ-029 If out_valid and timeout occur in the same cycle, out_valid SHALL win (status 00).
REQ-030 SHALL ignore out_valid in COLLECT, SEND and DONE.
REQ-031 On an overflowed frame, SHALL report status 01 with res_cost=0.
REQ-032 In DONE, SHALL assert res_valid=1 for exactly one cycle with res_cost/res_status stable; both hold their value until the next DONE.
REQ-033 On leaving DONE, SHALL clear wptr, rptr, ovf and the timer, and return to COLLECT.
REQ-034 Result latency SHALL be: res_valid the cycle after the out_valid cycle.

Reset
REQ-035 While rst_n=0, SHALL asynchronously force state COLLECT, with h_ready=0 during reset, and in_valid=0, source=0, destination=0, res_valid=0, res_cost=0, res_status=00, wptr=rptr=0, ovf=0, timer=0.
REQ-036 Reset asserted mid-SEND or mid-WAIT SHALL drop in_valid immediately and discard the frame; no res_valid is issued.
REQ-037 After reset release, h_ready SHALL rise on the first clock edge.

Verification
REQ-038 SHALL pass: frame (0,5),(0,1),(1,5) then out_valid with cost=2 three cycles later -> in_valid high 3 cycles carrying those words in order; res_valid one cycle later, res_cost=2, status 00.
REQ-039 SHALL pass: header-only frame (3,3) then out_valid with cost=0 -> a single in_valid cycle; res_cost=0, status 00.
REQ-040 SHALL pass: 18-word frame -> no in_valid; res_valid with status 01, res_cost=0; the next normal frame succeeds.
REQ-041 SHALL pass: valid frame with out_valid never asserted, TIMEOUT=8 -> res_valid 8 cycles after WAIT entry, status 10.
REQ-042 SHALL pass: out_valid on the timeout cycle with cost=7 -> status 00, res_cost=7.
REQ-043 SHALL pass: rst_n pulsed low during the second SEND cycle -> in_valid low immediately, no res_valid, h_ready=1 after release.
